// File: rtl/out_port_pkg.sv
// Shared constants and types for the out_port character output peripheral.
// Register offsets, STATUS bit positions and the drain FSM state encoding.
package out_port_pkg;

    localparam logic [3:0] DATA_OFS   = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_LEVEL_LSB = 8;

    typedef enum logic {
        IDLE,
        HOLD
    } drain_state_t;

endpackage

// File: rtl/out_fifo.sv
// Byte-wide synchronous FIFO with registered fill level; full/empty derive from it.
// Push on full and pop on empty are ignored so the pointers can never run past each other.
module out_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers are AW bits wide, so wrap modulo DEPTH is free for power-of-2 depths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/out_port.sv
// Memory-mapped character output: CPU byte writes queue in a FIFO and a drain FSM
// presents each byte on out_dat with an out_ctl toggle, spaced at least GAP+1 cycles apart.
//
//   state | meaning
//   IDLE  | waiting for a queued byte; pops and toggles out_ctl as soon as one exists
//   HOLD  | gap timer running after a toggle; returns to IDLE when cnt reaches 0
module out_port
    import out_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          GAP        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [7:0]  out_dat,
    output logic        out_ctl
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(GAP);

    logic          sel;
    logic          is_wr;
    logic          data_wr;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    head;
    logic [LW-1:0] level;
    logic [31:0]   status;
    drain_state_t  state;
    logic [CW-1:0] cnt;
    logic          unused_wdata;

    assign unused_wdata = ^mem_wdata[31:8];

    // Gating on !mem_ready keeps a held request from being acknowledged twice.
    assign sel     = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && !mem_ready;
    assign is_wr   = |mem_wstrb;
    assign data_wr = sel && is_wr && (mem_addr[3:0] == DATA_OFS) && mem_wstrb[0];
    assign push    = data_wr && !full;
    assign pop     = (state == IDLE) && !empty;

    always_comb begin
        status                        = '0;
        status[ST_FULL]               = full;
        status[ST_EMPTY]              = empty;
        status[ST_BUSY]               = (state != IDLE);
        status[ST_LEVEL_LSB +: 8]     = 8'(level);
    end

    out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (mem_wdata[7:0]),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // A DATA write into a full FIFO withholds mem_ready until a pop frees a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= sel && !(data_wr && full);
            mem_rdata <= (sel && !is_wr && (mem_addr[3:0] == STATUS_OFS)) ? status : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            out_dat <= '0;
            out_ctl <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        out_dat <= head;
                        out_ctl <= ~out_ctl;
                        cnt     <= CW'(GAP - 1);
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_port.sv
// Self-checking bench for out_port: directed scenarios plus random bus traffic,
// checked against a queue-based model of bytes accepted and toggles observed.
module tb_out_port;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 16;
    localparam int          GAP   = 4;
    localparam int          PER   = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [7:0]  out_dat;
    logic        out_ctl;

    out_port #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .GAP        (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .out_dat   (out_dat),
        .out_ctl   (out_ctl)
    );

    always #(PER/2) clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         n_acc = 0;
    int         n_pops = 0;
    int         n_stall_cyc = 0;
    longint     last_tog = 0;
    longint     ack_edge = 0;
    logic       last_ctl = 1'b0;
    logic [7:0] last_dat = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // STATUS as seen at edge_t reflects everything up to the previous edge.
    function automatic logic [31:0] status_model(input int pops, input longint last, input longint edge_t);
        int          lvl;
        logic [31:0] s;
        lvl     = n_acc - pops;
        s       = '0;
        s[0]    = (lvl == DEPTH);
        s[1]    = (lvl == 0);
        s[2]    = (pops > 0) && ((edge_t - PER - last) <= (GAP - 1) * PER);
        s[15:8] = lvl[7:0];
        return s;
    endfunction

    always @(negedge clk) begin : mon
        longint t;
        if (rst_n) begin
            if (out_ctl !== last_ctl) begin
                t        = $time - PER/2;
                last_ctl = out_ctl;
                chk("toggle_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("out_dat", out_dat, exp_q.pop_front());
                if (n_pops > 0) chk("toggle_gap", (t - last_tog) >= (GAP + 1) * PER, 1);
                last_tog = t;
                last_dat = out_dat;
                n_pops++;
            end else begin
                chk("dat_stable", out_dat, last_dat);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rd);
        bit     in_win, is_push, blocked, done;
        int     budget, pops_s;
        longint last_s, t_e;
        logic   exp_rdy;
        in_win  = (addr[31:4] == BASE[31:4]);
        is_push = in_win && (addr[3:0] == 4'h0) && wstrb[0];
        blocked = mem_ready;
        budget  = in_win ? 400 : 6;
        done    = 0;
        rd      = '0;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk);
            pops_s  = n_pops;
            last_s  = last_tog;
            t_e     = $time;
            exp_rdy = in_win && !(c == 0 && blocked) && !(is_push && (n_acc - pops_s) >= DEPTH);
            #1;
            chk("mem_ready", mem_ready, exp_rdy);
            if (is_push && !mem_ready && !(c == 0 && blocked)) n_stall_cyc++;
            if (mem_ready) begin
                done     = 1;
                rd       = mem_rdata;
                ack_edge = t_e;
                if (is_push) begin
                    n_acc++;
                    exp_q.push_back(wdata[7:0]);
                end
                if (wstrb == 4'h0)
                    chk("rdata", mem_rdata,
                        (addr[3:0] == 4'h4) ? status_model(pops_s, last_s, t_e) : 32'h0);
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = '0;
        if (in_win) chk("ack_timeout", done, 1);
    endtask

    task automatic drain_wait();
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(posedge clk);
        idle(GAP + 2);
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin : stim
        logic [31:0] rd;
        logic [31:0] addr;
        logic [3:0]  strb;
        int          p0, r;
        logic [7:0]  hi [3];
        hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0A;

        #2 rst_n = 1'b0;
        #10;
        chk("rst_out_ctl", out_ctl, 0);
        chk("rst_out_dat", out_dat, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        #14 rst_n = 1'b1;

        // single byte: latency and idle STATUS
        bus_xfer(BASE, 32'h41, 4'b0001, rd);
        idle(2);
        chk("first_latency", last_tog, ack_edge + PER);
        chk("first_dat", out_dat, 8'h41);
        idle(6);
        bus_xfer(BASE + 4, 32'h0, 4'h0, rd);
        chk("status_idle", rd, 32'h2);

        // "Hi\n" back-to-back
        p0 = n_pops;
        for (int i = 0; i < 3; i++) bus_xfer(BASE, {24'h0, hi[i]}, 4'hF, rd);
        idle(25);
        chk("hi_count", n_pops - p0, 3);

        // overfill: later writes must stall until a pop
        for (int i = 0; i < 34; i++) bus_xfer(BASE, $urandom, 4'hF, rd);
        bus_xfer(BASE + 4, 32'h0, 4'h0, rd);
        chk("fill_full", rd[0], 1);
        chk("fill_level", rd[15:8], DEPTH);
        chk("stall_seen", n_stall_cyc > 0, 1);
        drain_wait();

        // mid-drain STATUS and a DATA write without byte-0 strobe
        p0 = n_pops;
        bus_xfer(BASE, 32'hA5, 4'hF, rd);
        bus_xfer(BASE, 32'h5A, 4'hF, rd);
        bus_xfer(BASE + 4, 32'h0, 4'h0, rd);
        chk("mid_busy", rd[2], 1);
        bus_xfer(BASE, 32'h77, 4'b0010, rd);
        bus_xfer(BASE, 32'h33, 4'hF, rd);
        drain_wait();
        chk("mid_count", n_pops - p0, 3);

        // reset during HOLD with bytes queued
        for (int i = 0; i < 9; i++) bus_xfer(BASE, $urandom, 4'hF, rd);
        #3 rst_n = 1'b0;
        exp_q.delete();
        n_acc = 0; n_pops = 0; last_ctl = 1'b0; last_dat = '0;
        #1;
        chk("mrst_out_ctl", out_ctl, 0);
        chk("mrst_out_dat", out_dat, 0);
        chk("mrst_mem_ready", mem_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus_xfer(BASE + 4, 32'h0, 4'h0, rd);
        chk("mrst_status", rd, 32'h2);
        idle(30);
        chk("mrst_no_toggle", n_pops, 0);

        // unused offset, DATA read, out-of-window accesses
        bus_xfer(BASE + 8, 32'h0, 4'h0, rd);
        bus_xfer(BASE + 8, 32'h55, 4'hF, rd);
        bus_xfer(BASE + 0, 32'h0, 4'h0, rd);
        bus_xfer(32'h2000_0000, 32'h0, 4'h0, rd);
        bus_xfer(BASE + 32'h10, 32'h66, 4'hF, rd);
        idle(10);
        chk("window_no_push", n_pops, 0);

        // random traffic
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                strb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
                bus_xfer(BASE, $urandom, strb, rd);
            end else if (r <= 6) begin
                bus_xfer(BASE + 4, $urandom, 4'h0, rd);
            end else if (r == 7) begin
                bus_xfer(BASE + 32'($urandom_range(0, 15)), $urandom, 4'h0, rd);
            end else if (r == 8) begin
                bus_xfer(BASE + 32'($urandom_range(1, 15)), $urandom, 4'($urandom_range(1, 15)), rd);
            end else begin
                addr = $urandom;
                if (addr[31:4] == BASE[31:4]) addr[31] = ~addr[31];
                bus_xfer(addr, $urandom, 4'($urandom_range(0, 15)), rd);
            end
            idle($urandom_range(0, 3));
        end
        drain_wait();
        bus_xfer(BASE + 4, 32'h0, 4'h0, rd);
        chk("final_status", rd, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
